// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch front end.
//   XLEN          address / instruction width
//   FETCH_DEPTH   default depth of the tag queue and instruction buffer
//   INST_NOP      canonical no-op encoding (addi x0, x0, 0)
//   fetch_entry_t {pc, inst} pair held in the instruction buffer
//   align_pc()    word-aligns a fetch address
// ----------------------------------------------------------------------------
package if_pkg;

    localparam int XLEN        = 32;
    localparam int FETCH_DEPTH = 4;

    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage and first-word-fall-through head.
//   clk    in   clock
//   rst    in   synchronous reset, active-low
//   push   in   write din (ignored when full unless a pop happens together)
//   pop    in   drop head entry (ignored when empty)
//   clear  in   empty the FIFO at the next edge; dominates push/pop
//   din    in   write data
//   dout   out  head entry (only meaningful while ~empty)
//   full   out  count == DEPTH
//   empty  out  count == 0
//   count  out  number of stored entries
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign dout    = mem[rd_ptr];

    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end. Accepts fetch PCs, issues in-order reads to
// instruction memory, tags each read with its PC and buffers the returned
// words for decode. A flush drops every buffered and in-flight fetch.
//   clk             in   clock
//   rst             in   synchronous reset, active-low
//   pc_valid        in   fetch PC offered by the PC generator
//   pc_addr         in   fetch PC (bits [1:0] ignored)
//   pc_ready        out  fetch PC accepted this cycle
//   flush           in   redirect; kill all older fetches
//   imem_req_valid  out  memory read request
//   imem_req_addr   out  word-aligned read address
//   imem_req_ready  in   memory accepts the request
//   imem_rsp_valid  in   read data returned (in order, no backpressure)
//   imem_rsp_data   in   returned instruction word
//   inst_valid      out  instruction available to decode
//   inst_pc         out  PC of the presented instruction
//   inst_data       out  presented instruction
//   inst_ready      in   decode consumes the head entry
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid,
    input  logic [XLEN-1:0] pc_addr,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] inst_data,
    input  logic            inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     occupancy;
    logic            credit;
    logic            req_fire;
    logic            rsp_fire;

    logic [XLEN-1:0] tag_head;
    logic            tag_empty;
    logic            tag_full_unused;
    logic [CW-1:0]   tag_count_unused;

    fetch_entry_t    buf_din;
    fetch_entry_t    buf_head;
    logic            buf_push;
    logic            buf_pop;
    logic            buf_empty;
    logic            buf_full_unused;

    // Every in-flight request owns a buffer slot, so the buffer cannot overflow.
    assign occupancy      = {1'b0, outstanding} + {1'b0, buf_count};
    assign credit         = (occupancy < (CW+1)'(DEPTH));

    assign imem_req_valid = pc_valid & credit & ~flush & rst;
    assign imem_req_addr  = align_pc(pc_addr);
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign pc_ready       = req_fire;

    // A response with no matching tag is a protocol error and is ignored.
    assign rsp_fire       = imem_rsp_valid & ~tag_empty;

    // Wrong-path words (discard pending) and words arriving with a flush are dropped.
    assign buf_push       = rsp_fire & ~flush & (discard == '0);
    assign buf_pop        = ~buf_empty & inst_ready;
    assign buf_din        = '{pc: tag_head, inst: imem_rsp_data};

    assign inst_valid     = ~buf_empty;
    assign inst_pc        = inst_valid ? buf_head.pc   : '0;
    assign inst_data      = inst_valid ? buf_head.inst : '0;

    // The tag queue is never flushed: tags of killed requests still pair
    // with their (discarded) responses to keep the stream aligned.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (rsp_fire),
        .clear (1'b0),
        .din   (imem_req_addr),
        .dout  (tag_head),
        .full  (tag_full_unused),
        .empty (tag_empty),
        .count (tag_count_unused)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_inst_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (buf_pop),
        .clear (flush),
        .din   (buf_din),
        .dout  (buf_head),
        .full  (buf_full_unused),
        .empty (buf_empty),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
            // On flush every request still in flight after this cycle's
            // response is wrong-path. Reloading (not adding) avoids double
            // counting when a flush lands while an earlier discard is pending.
            if (flush) begin
                discard <= outstanding - CW'(rsp_fire);
            end else if (rsp_fire && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
    import if_pkg::*;

    localparam int DEPTH = FETCH_DEPTH;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            pc_valid = 1'b0;
    logic [XLEN-1:0] pc_addr = '0;
    logic            pc_ready;
    logic            flush = 1'b0;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready = 1'b0;
    logic            imem_rsp_valid = 1'b0;
    logic [XLEN-1:0] imem_rsp_data = '0;
    logic            inst_valid;
    logic [XLEN-1:0] inst_pc;
    logic [XLEN-1:0] inst_data;
    logic            inst_ready = 1'b0;

    if_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_valid       (pc_valid),
        .pc_addr        (pc_addr),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit killed; } flight_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    fetch_entry_t sb[$];      // instructions decode should see, in order
    flight_t      flight[$];  // model of requests issued but not answered
    mreq_t        memq[$];    // memory model pending reads

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int fires = 0;
    bit last_fire = 0;
    bit chk_en = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ INST_NOP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, memory response, check request side,
    // then advance the reference model across the coming edge.
    task automatic step(input bit r, input bit pv, input logic [31:0] a,
                        input bit fl, input bit ir, input bit qr);
        bit      credit, exp_v, exp_fire;
        flight_t f;
        int      lat;
        @(negedge clk);
        cyc++;
        rst = r; pc_valid = pv; pc_addr = a; flush = fl;
        inst_ready = ir; imem_req_ready = qr;
        if (r && memq.size() != 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #2;
        credit   = (flight.size() + sb.size()) < DEPTH;
        exp_v    = r & pv & credit & ~fl;
        exp_fire = exp_v & qr;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_v));
        chk("pc_ready", 32'(pc_ready), 32'(exp_fire));
        if (exp_v && imem_req_valid)
            chk("req_addr", imem_req_addr, a & 32'hFFFF_FFFC);
        last_fire = pc_ready;
        if (pc_ready) fires++;
        if (r && imem_req_valid && imem_req_ready) begin
            lat = $urandom_range(lat_max, lat_min);
            memq.push_back('{imem_req_addr, cyc + lat});
        end
        if (!r) begin
            sb.delete(); flight.delete(); memq.delete();
        end else if (fl) begin
            if (imem_rsp_valid && flight.size() != 0) void'(flight.pop_front());
            sb.delete();
            foreach (flight[i]) flight[i].killed = 1'b1;
        end else begin
            if (sb.size() != 0 && ir) void'(sb.pop_front());
            if (imem_rsp_valid && flight.size() != 0) begin
                f = flight.pop_front();
                if (!f.killed) sb.push_back('{pc: f.pc, inst: mem_word(f.pc)});
            end
            if (exp_fire) flight.push_back('{a & 32'hFFFF_FFFC, 1'b0});
        end
    endtask

    // Offer one PC until accepted (bounded).
    task automatic offer(input logic [31:0] a, input bit ir);
        for (int i = 0; i < 40; i++) begin
            step(1, 1, a, 0, ir, 1);
            if (last_fire) return;
        end
        chk("accept_timeout", 32'(last_fire), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 80; i++) begin
            if (flight.size() == 0 && sb.size() == 0 && !inst_valid) return;
            step(1, 0, 0, 0, 1, 1);
        end
        chk("drain_timeout", 32'(inst_valid), 32'd0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 1, $urandom, 0, 1, 1);
        @(negedge clk);
        #1;
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
    endtask

    // Monitor: compares what decode sees against the scoreboard each cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                chk("inst_valid", 32'(inst_valid), 32'(sb.size() != 0));
                if (inst_valid && sb.size() != 0) begin
                    chk("inst_pc", inst_pc, sb[0].pc);
                    chk("inst_data", inst_data, sb[0].inst);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [31:0] addrs [6];
        @(posedge clk);
        chk_en = 1'b1;

        // reset with a PC offered
        do_reset(3);

        // in-order stream, latency 1
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 4; i++) offer(32'(i * 4), 1);
        drain();

        // backpressure: decode stalled, 6 PCs offered
        for (int i = 0; i < 6; i++) addrs[i] = 32'h200 + 32'(i * 4);
        fires = 0; idx = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 1, addrs[idx], 0, 0, 1);
            if (last_fire && idx < 5) idx++;
        end
        chk("bp_fires", 32'(fires), 32'd4);
        while (idx < 6) begin
            offer(addrs[idx], 1);
            idx++;
        end
        drain();

        // flush with 2 outstanding and 1 buffered
        step(1, 1, 32'h300, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        lat_min = 6; lat_max = 6;
        step(1, 1, 32'h304, 0, 0, 1);
        step(1, 1, 32'h308, 0, 0, 1);
        step(1, 1, 32'h100, 1, 0, 1);
        lat_min = 1; lat_max = 1;
        offer(32'h100, 1);
        drain();

        // flush coincident with response and request
        step(1, 1, 32'h400, 0, 1, 1);
        step(1, 1, 32'h404, 0, 1, 1);
        step(1, 1, 32'h408, 1, 1, 1);
        offer(32'h408, 1);
        drain();

        // misaligned PC
        offer(32'h0000_0106, 1);
        drain();

        // randomized traffic with a mid-run reset
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset(2);
            end
            step(1, ($urandom % 10) < 7, $urandom, ($urandom % 20) == 0,
                 ($urandom % 10) < 6, ($urandom % 4) != 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
